// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Receives a framed program image over a byte stream, writes it
//            word-by-word into instruction memory, verifies an XOR checksum,
//            and then releases the processor from reset at BASE_ADDR.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_wr_en,
  output logic [63:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_resetl,
  output logic [63:0] startpc,
  output logic        loading,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [7:0]  C_SYNC = 8'hA5;
  // One bit wider than the count field so MAX_WORDS up to 65535 compares cleanly.
  localparam logic [16:0] C_MAX  = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] count_q, count_d;
  logic [15:0] index_q, index_d;
  logic [1:0]  pos_q, pos_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        wr_en_q, wr_en_d;
  logic [63:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        resetl_q, loading_q, done_q, error_q;

  logic        w_open;
  logic        w_accept;
  logic [15:0] w_count;

  // Byte acceptance: open in the frame-parsing states, but closed during the
  // write cycle so a new byte never collides with the word being committed.
  assign w_open   = (state_q == S_IDLE) || (state_q == S_CNT_LO) ||
                    (state_q == S_CNT_HI) || (state_q == S_DATA) ||
                    (state_q == S_CSUM);
  assign rx_ready = w_open && !wr_en_q;
  assign w_accept = rx_valid && rx_ready;
  assign w_count  = {rx_data, cnt_lo_q};

  // Next-state decode for the frame parser and the memory write port.
  always_comb begin
    state_d   = state_q;
    cnt_lo_d  = cnt_lo_q;
    count_d   = count_q;
    index_d   = index_q;
    pos_d     = pos_q;
    word_d    = word_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept && (rx_data == C_SYNC)) begin
          state_d = S_CNT_LO;
          csum_d  = 8'h00;
        end
      end
      S_CNT_LO: begin
        if (w_accept) begin
          cnt_lo_d = rx_data;
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (w_accept) begin
          count_d = w_count;
          if ((w_count == 16'd0) || ({1'b0, w_count} > C_MAX)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            index_d = 16'd0;
            pos_d   = 2'd0;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          csum_d = csum_q ^ rx_data;
          pos_d  = pos_q + 2'd1;
          case (pos_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              // Fourth byte completes the little-endian word; commit it.
              wr_en_d   = 1'b1;
              wr_data_d = {rx_data, word_q};
              wr_addr_d = BASE_ADDR + {46'd0, index_q, 2'b00};
              index_d   = index_q + 16'd1;
              if ((index_q + 16'd1) == count_q) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
        end
      end
      default: begin
        // RUN and ERR are terminal until reset.
        state_d = state_q;
      end
    endcase
  end

  // State and registered outputs; status flags decode the state being entered.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_lo_q  <= 8'h00;
      count_q   <= 16'd0;
      index_q   <= 16'd0;
      pos_q     <= 2'd0;
      word_q    <= 24'd0;
      csum_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 64'd0;
      wr_data_q <= 32'd0;
      resetl_q  <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_lo_q  <= cnt_lo_d;
      count_q   <= count_d;
      index_q   <= index_d;
      pos_q     <= pos_d;
      word_q    <= word_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      resetl_q  <= (state_d == S_RUN);
      loading_q <= (state_d == S_CNT_LO) || (state_d == S_CNT_HI) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
      done_q    <= (state_d == S_RUN);
      error_q   <= (state_d == S_ERR);
    end
  end

  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign cpu_resetl   = resetl_q;
  assign startpc      = BASE_ADDR;
  assign loading      = loading_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed vector table plus hand-written frame sequences for the
//            instruction-memory boot loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_wr_en;
  logic [63:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        cpu_resetl;
  logic [63:0] startpc;
  logic        loading;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  imem_boot_loader dut (
    .CLK          (CLK),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_resetl   (cpu_resetl),
    .startpc      (startpc),
    .loading      (loading),
    .done         (done),
    .error        (error)
  );

  always #5 CLK = ~CLK;

  // Flags ordering: {rx_ready, imem_wr_en, cpu_resetl, loading, done, error}
  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic [5:0]  flags;
    logic [63:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vtab[$];

  // Write capture: each write strobe is one cycle wide, so one negedge sees it.
  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        rdy_chk = 1'b0;
  int          rdy_bad = 0;

  always @(negedge CLK) begin
    if (imem_wr_en) begin
      wr_addr_q.push_back(imem_wr_addr);
      wr_data_q.push_back(imem_wr_data);
    end
    if (rdy_chk && (rx_ready == imem_wr_en)) rdy_bad++;
  end

  task automatic add(input logic rst, input logic v, input logic [7:0] d,
                     input logic [5:0] flags, input logic [63:0] addr,
                     input logic [31:0] wdata);
    vec_t e;
    e.rst = rst; e.v = v; e.d = d; e.flags = flags; e.addr = addr; e.wdata = wdata;
    vtab.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; rx_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Present a byte until the DUT accepts it, with a bounded wait.
  task automatic send(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge CLK);
      rx_valid = 1'b1; rx_data = b;
      #1 acc = rx_ready;
      @(posedge CLK);
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: byte %0h never accepted (ready stayed 0, required 1)", b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      rx_valid = 1'b0;
      @(posedge CLK);
    end
  endtask

  task automatic send_list(input logic [7:0] bytes[$], input logic gap);
    foreach (bytes[i]) begin
      send(bytes[i]);
      if (gap) idle(1);
    end
  endtask

  initial begin
    logic [5:0] act_flags;
    logic [7:0] fr[$];

    // Cycle-by-cycle vectors: expected outputs as seen just after each edge.
    // Two-word frame: data bytes E5 03 1F 8B 20 00 80 D2 XOR to 0x00.
    add(1, 0, 8'h00, 6'b100000, 64'h0, 32'h0);
    add(0, 1, 8'hA5, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h02, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h00, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'hE5, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h03, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h1F, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h8B, 6'b010100, 64'h0, 32'h8B1F03E5);
    add(0, 1, 8'h20, 6'b100100, 64'h0, 32'h8B1F03E5);  // refused: write cycle
    add(0, 1, 8'h20, 6'b100100, 64'h0, 32'h8B1F03E5);
    add(0, 1, 8'h00, 6'b100100, 64'h0, 32'h8B1F03E5);
    add(0, 1, 8'h80, 6'b100100, 64'h0, 32'h8B1F03E5);
    add(0, 1, 8'hD2, 6'b010100, 64'h4, 32'hD2800020);
    add(0, 1, 8'h00, 6'b100100, 64'h4, 32'hD2800020);  // refused: write cycle
    add(0, 1, 8'h00, 6'b001010, 64'h4, 32'hD2800020);  // checksum ok -> run
    add(0, 1, 8'hA5, 6'b001010, 64'h4, 32'hD2800020);  // ignored in run
    add(1, 1, 8'hA5, 6'b100000, 64'h0, 32'h0);         // reset wins over byte
    // Leading junk then a one-word frame, checksum 11^22^33^44 = 0x44.
    add(0, 1, 8'h00, 6'b100000, 64'h0, 32'h0);
    add(0, 1, 8'hFF, 6'b100000, 64'h0, 32'h0);
    add(0, 1, 8'hA5, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h01, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h00, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h11, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h22, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h33, 6'b100100, 64'h0, 32'h0);
    add(0, 1, 8'h44, 6'b010100, 64'h0, 32'h44332211);
    add(0, 0, 8'h00, 6'b100100, 64'h0, 32'h44332211);
    add(0, 1, 8'h44, 6'b001010, 64'h0, 32'h44332211);

    for (int i = 0; i < vtab.size(); i++) begin
      @(negedge CLK);
      reset = vtab[i].rst; rx_valid = vtab[i].v; rx_data = vtab[i].d;
      @(posedge CLK);
      #1;
      act_flags = {rx_ready, imem_wr_en, cpu_resetl, loading, done, error};
      vectors++;
      if (act_flags !== vtab[i].flags || imem_wr_addr !== vtab[i].addr ||
          imem_wr_data !== vtab[i].wdata || startpc !== 64'h0) begin
        miscompares++;
        $display("FAIL vec%0d: got flags=%b addr=%0h data=%0h pc=%0h expected flags=%b addr=%0h data=%0h pc=0",
                 i, act_flags, imem_wr_addr, imem_wr_data, startpc,
                 vtab[i].flags, vtab[i].addr, vtab[i].wdata);
      end
    end

    // Zero word count is rejected.
    do_reset();
    fr = '{8'hA5, 8'h00, 8'h00};
    send_list(fr, 1'b0);
    idle(2);
    chk("cnt0_error", {63'd0, error}, 64'd1);
    chk("cnt0_resetl", {63'd0, cpu_resetl}, 64'd0);
    chk("cnt0_ready", {63'd0, rx_ready}, 64'd0);
    chk("cnt0_writes", wr_addr_q.size(), 64'd0);

    // 257 words exceeds the limit.
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h01};
    send_list(fr, 1'b0);
    idle(2);
    chk("cnt257_error", {63'd0, error}, 64'd1);
    chk("cnt257_flags", {60'd0, cpu_resetl, loading, done, imem_wr_en}, 64'd0);

    // Exactly 256 words is the largest legal count.
    do_reset();
    fr = '{8'hA5, 8'h00, 8'h01};
    send_list(fr, 1'b0);
    idle(1);
    chk("cnt256_loading", {62'd0, loading, error}, 64'd2);

    // Bad checksum after one word: write stays, processor held.
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_list(fr, 1'b0);
    idle(2);
    chk("badcs_writes", wr_addr_q.size(), 64'd1);
    if (wr_addr_q.size() == 1) begin
      chk("badcs_addr", wr_addr_q[0], 64'h0);
      chk("badcs_data", {32'd0, wr_data_q[0]}, 64'h04030201);
    end
    chk("badcs_flags", {59'd0, rx_ready, cpu_resetl, loading, done, error}, 64'd1);

    // Gapped input during data: same writes, ready low only on write cycles.
    do_reset();
    fr = '{8'hA5, 8'h02, 8'h00};
    send_list(fr, 1'b0);
    rdy_bad = 0;
    rdy_chk = 1'b1;
    fr = '{8'hE5, 8'h03, 8'h1F, 8'h8B, 8'h20, 8'h00, 8'h80, 8'hD2};
    send_list(fr, 1'b1);
    rdy_chk = 1'b0;
    send(8'h00);
    idle(1);
    chk("gap_ready_vs_wr", rdy_bad, 64'd0);
    chk("gap_writes", wr_addr_q.size(), 64'd2);
    if (wr_addr_q.size() == 2) begin
      chk("gap_addr0", wr_addr_q[0], 64'h0);
      chk("gap_data0", {32'd0, wr_data_q[0]}, 64'h8B1F03E5);
      chk("gap_addr1", wr_addr_q[1], 64'h4);
      chk("gap_data1", {32'd0, wr_data_q[1]}, 64'hD2800020);
    end
    chk("gap_done", {62'd0, done, cpu_resetl}, 64'd3);

    // Reset mid-word abandons the frame; the retry starts at the base address.
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_list(fr, 1'b0);
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_list(fr, 1'b0);
    idle(1);
    chk("midrst_writes", wr_addr_q.size(), 64'd1);
    if (wr_addr_q.size() == 1) begin
      chk("midrst_addr", wr_addr_q[0], 64'h0);
      chk("midrst_data", {32'd0, wr_data_q[0]}, 64'h44332211);
    end
    chk("midrst_done", {62'd0, done, error}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
